// File: rtl/ama_riscv_pkg.sv
// Shared core definitions used by the fetch stage.
package ama_riscv_pkg;

  localparam logic [31:0] NOP            = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR   = 32'h0004_0000;
  localparam int unsigned IMEM_DELAY_CLK = 1;

  // Next fetch PC source
  typedef enum logic {
    PC_SEL_INC4 = 1'b0,
    PC_SEL_ALU  = 1'b1
  } pc_sel_t;

  // Fetch control states
  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FLUSH = 1'b1
  } fetch_state_t;

  // Instruction buffer entry
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ama_riscv_fifo.sv
// Synchronous FIFO; push and pop may both happen while full.
module ama_riscv_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt < CNT_W'(DEPTH)) || do_pop);

  // Pointer and occupancy tracking; clear empties the buffer
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/ama_riscv_fetch.sv
// Instruction fetch: credit-limited IMEM requests, response buffer, redirect flush.
module ama_riscv_fetch
  import ama_riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1) + 1;
  localparam int unsigned FCNT_W = $clog2(DEPTH + 1);

  fetch_state_t      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              hold_q, hold_d;
  logic [CNT_W-1:0]  occupancy;
  logic              credit_ok;
  logic              req_fire;
  logic              dec_fire;
  pc_sel_t           pc_sel;

  fetch_entry_t      fifo_din, fifo_dout;
  logic              fifo_push, fifo_pop, fifo_clr, fifo_empty;
  logic [FCNT_W-1:0] fifo_count;

  // Credits: kept requests in flight plus buffered entries, minus the entry leaving now
  assign dec_fire  = dec_valid & dec_ready;
  assign occupancy = out_q - drop_q + CNT_W'(fifo_count) - CNT_W'(dec_fire);
  assign credit_ok = occupancy < CNT_W'(DEPTH);

  // An unaccepted request stays up until it fires; a redirect withdraws it
  assign imem_req_valid = !rst && !redirect_valid &&
                          (hold_q || ((state_q == FETCH_RUN) && credit_ok));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Next-state: PC select, in-flight/drop accounting, buffer control
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    rsp_pc_d  = rsp_pc_q;
    drop_d    = drop_q;
    hold_d    = imem_req_valid & ~imem_req_ready;
    pc_sel    = PC_SEL_INC4;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    fifo_clr  = 1'b0;
    fifo_din  = '{pc: rsp_pc_q, inst: imem_rsp_data};
    out_d     = out_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

    if (redirect_valid) begin
      // Everything still in flight belongs to the old path
      pc_sel   = PC_SEL_ALU;
      fifo_clr = 1'b1;
      drop_d   = out_d;
      rsp_pc_d = redirect_pc;
    end else begin
      fifo_pop = dec_fire;
      if (imem_rsp_valid) begin
        if (state_q == FETCH_FLUSH) begin
          drop_d = drop_q - CNT_W'(1);
        end else begin
          fifo_push = 1'b1;
          rsp_pc_d  = rsp_pc_q + 32'd4;
        end
      end
    end

    case (pc_sel)
      PC_SEL_ALU: pc_d = redirect_pc;
      default:    if (req_fire) pc_d = pc_q + 32'd4;
    endcase

    state_d = (drop_d != '0) ? FETCH_FLUSH : FETCH_RUN;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH_RUN;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      hold_q   <= hold_d;
    end
  end

  ama_riscv_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign dec_valid = ~fifo_empty;
  assign dec_inst  = dec_valid ? fifo_dout.inst : NOP;
  assign dec_pc    = dec_valid ? fifo_dout.pc : 32'd0;

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Directed bench for the fetch stage with a latency-configurable IMEM model.
module tb_ama_riscv_fetch;
  import ama_riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;

  int n_chk  = 0;
  int n_pass = 0;

  int          lat = 1;
  int          cyc = 0;
  logic [31:0] q_addr [$];
  int          q_due  [$];
  logic [31:0] fired  [$];
  logic [31:0] got_pc [$];
  logic [31:0] got_inst [$];
  int          got_cyc [$];
  int          fires, pops, occ_max;

  ama_riscv_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  // IMEM model (in order, fixed latency) and decode-side monitor
  always @(posedge clk) begin
    if (rst) begin
      q_addr.delete(); q_due.delete(); fired.delete();
      got_pc.delete(); got_inst.delete(); got_cyc.delete();
      fires = 0; pops = 0; occ_max = 0;
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        q_addr.push_back(imem_req_addr);
        q_due.push_back(cyc + lat - 1);
        fired.push_back(imem_req_addr);
        fires++;
      end
      if (dec_valid && dec_ready && !redirect_valid) begin
        got_pc.push_back(dec_pc);
        got_inst.push_back(dec_inst);
        got_cyc.push_back(cyc);
        pops++;
      end
      if (fires - pops > occ_max) occ_max = fires - pops;
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= inst_of(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
        imem_rsp_data  <= '0;
      end
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget && got_pc.size() < n; i++) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_dec_valid"}, 32'(dec_valid), 32'd0);
    check({tag, "_dec_inst"}, dec_inst, NOP);
    check({tag, "_dec_pc"}, dec_pc, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int idx;
    rst = 1'b1; imem_req_ready = 1'b1; dec_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; lat = 1;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst");

    // Release: first three request addresses
    rst = 1'b0;
    #1;
    check("rel_valid0", 32'(imem_req_valid), 32'd1);
    check("rel_addr0", imem_req_addr, 32'h0004_0000);
    @(negedge clk); #1;
    check("rel_addr1", imem_req_addr, 32'h0004_0004);
    @(negedge clk); #1;
    check("rel_valid2", 32'(imem_req_valid), 32'd1);
    check("rel_addr2", imem_req_addr, 32'h0004_0008);

    // Streaming at one instruction per cycle
    wait_got(10, 40);
    check("stream_cnt", 32'(got_pc.size()), 32'd10);
    for (int i = 1; i < 8; i++) check("stream_gap", 32'(got_cyc[i] - got_cyc[i-1]), 32'd1);

    // Decode stall for six cycles
    dec_ready = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("stall_no_req", 32'(imem_req_valid), 32'd0);
    check("stall_dec_valid", 32'(dec_valid), 32'd1);
    dec_ready = 1'b1;
    wait_got(20, 60);
    check("stall_cnt", 32'(got_pc.size()), 32'd20);
    for (int i = 0; i < 20; i++) begin
      check("seq_pc", got_pc[i], 32'h0004_0000 + 32'(4 * i));
      check("seq_inst", got_inst[i], inst_of(32'h0004_0000 + 32'(4 * i)));
    end
    check("occ_max", 32'(occ_max), 32'd2);

    // Redirect with two requests in flight (latency 3)
    rst = 1'b1; lat = 3;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("fl_inflight", 32'(q_addr.size()), 32'd2);
    check("fl_no_credit", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0004_0100;
    idx = fired.size();
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("fl_no_req", 32'(imem_req_valid), 32'd0);
    wait_got(1, 30);
    check("fl_cnt", 32'(got_pc.size()), 32'd1);
    check("fl_pc", got_pc[0], 32'h0004_0100);
    check("fl_inst", got_inst[0], inst_of(32'h0004_0100));
    check("fl_fired_before", 32'(idx), 32'd2);
    check("fl_first_req", fired[idx], 32'h0004_0100);

    // Redirect coinciding with a response and a decode transfer
    rst = 1'b1; lat = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_got(5, 30);
    #1;
    check("rd_pre_dec_valid", 32'(dec_valid), 32'd1);
    check("rd_pre_rsp", 32'(imem_rsp_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0004_0200;
    n0 = got_pc.size();
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("rd_cleared", 32'(dec_valid), 32'd0);
    check("rd_req_valid", 32'(imem_req_valid), 32'd1);
    check("rd_req_addr", imem_req_addr, 32'h0004_0200);
    wait_got(n0 + 1, 30);
    check("rd_cnt", 32'(got_pc.size()), 32'(n0 + 1));
    check("rd_last_old", got_pc[n0-1], 32'h0004_0010);
    check("rd_first_pc", got_pc[n0], 32'h0004_0200);

    // Reset pulse with a full buffer, restart with a held request
    dec_ready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("full_dec_valid", 32'(dec_valid), 32'd1);
    check("full_no_req", 32'(imem_req_valid), 32'd0);
    rst = 1'b1; imem_req_ready = 1'b0;
    @(negedge clk); #1;
    check_reset_outputs("pulse");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_valid", 32'(imem_req_valid), 32'd1);
      check("hold_addr", imem_req_addr, 32'h0004_0000);
      @(negedge clk);
    end
    imem_req_ready = 1'b1; dec_ready = 1'b1;
    @(negedge clk); #1;
    check("restart_addr1", imem_req_addr, 32'h0004_0004);
    wait_got(1, 20);
    check("restart_cnt", 32'(got_pc.size()), 32'd1);
    check("restart_pc", got_pc[0], 32'h0004_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
